// File: rtl/array_pkg.sv
// array_pkg: shared geometry of the 128 x 108 masked SRAM and the controller state type.
package array_pkg;
    localparam int ARRAY_DEPTH    = 128;
    localparam int ARRAY_AW       = 7;
    localparam int ARRAY_WIDTH    = 108;
    localparam int ARRAY_MASK_SEG = 4;
    localparam int ARRAY_GRAN     = 27;
    typedef enum logic {ST_INIT, ST_RUN} state_e;
endpackage

// File: rtl/array_ext.sv
// array_ext: behavioural single-port masked SRAM, write-first, registered read address, no reset.
module array_ext
    import array_pkg::*;
#(
    parameter int DEPTH    = ARRAY_DEPTH,
    parameter int AW       = ARRAY_AW,
    parameter int WIDTH    = ARRAY_WIDTH,
    parameter int MASK_SEG = ARRAY_MASK_SEG,
    parameter int GRAN     = ARRAY_GRAN
) (
    input  logic                RW0_clk,
    input  logic [AW-1:0]       RW0_addr,
    input  logic                RW0_en,
    input  logic                RW0_wmode,
    input  logic [MASK_SEG-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]    RW0_wdata,
    output logic [WIDTH-1:0]    RW0_rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    addr_q;

    always_ff @(posedge RW0_clk)
        if (RW0_en && RW0_wmode) begin
            for (int s = 0; s < MASK_SEG; s++)
                if (RW0_wmask[s]) mem_q[RW0_addr][s*GRAN +: GRAN] <= RW0_wdata[s*GRAN +: GRAN];
        end else if (RW0_en) begin
            addr_q <= RW0_addr;
        end

    assign RW0_rdata = mem_q[addr_q];
endmodule

// File: rtl/array_resp_fifo.sv
// array_resp_fifo: 2-entry response buffer; head reads as zero while empty.
module array_resp_fifo
    import array_pkg::*;
#(
    parameter int WIDTH = ARRAY_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q, rd_q;
    logic [1:0]       cnt_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= !wr_q;
            end
            if (pop_i) rd_q <= !rd_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end

    assign count_o = cnt_q;
    assign head_o  = cnt_q != 2'd0 ? mem_q[rd_q] : '0;
endmodule

// File: rtl/array_port_ctrl.sv
// array_port_ctrl: request/response controller for the masked SRAM macro,
// zero-sweeping the array after reset and buffering read data under backpressure.
module array_port_ctrl
    import array_pkg::*;
#(
    parameter int DEPTH        = ARRAY_DEPTH,
    parameter int AW           = ARRAY_AW,
    parameter int WIDTH        = ARRAY_WIDTH,
    parameter int MASK_SEG     = ARRAY_MASK_SEG,
    parameter int GRAN         = ARRAY_GRAN,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [AW-1:0]       req_addr,
    input  logic [MASK_SEG-1:0] req_mask,
    input  logic [WIDTH-1:0]    req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WIDTH-1:0]    resp_rdata,
    output logic                init_done,
    output logic [AW-1:0]       RW0_addr,
    output logic                RW0_en,
    output logic                RW0_wmode,
    output logic [MASK_SEG-1:0] RW0_wmask,
    output logic [WIDTH-1:0]    RW0_wdata,
    input  logic [WIDTH-1:0]    RW0_rdata
);
    if (WIDTH != MASK_SEG * GRAN) begin : g_bad_geometry
        $error("array_port_ctrl: WIDTH must equal MASK_SEG*GRAN");
    end

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          done_q, inflight_q;
    logic [1:0]    fifo_cnt, outstanding;
    logic          pop, fire, sweep;

    // Credit counts a read as soon as it is issued, so the FIFO can never overflow.
    assign pop         = resp_valid && resp_ready;
    assign outstanding = fifo_cnt + {1'b0, inflight_q} - {1'b0, pop};
    assign req_ready   = state_q == ST_RUN && outstanding < 2'd2;
    assign fire        = req_valid && req_ready;
    // Sweep is gated by reset so the macro sees no access while reset is held.
    assign sweep       = CLR_ON_RESET && state_q == ST_INIT && !reset;

    assign RW0_en    = sweep || fire;
    assign RW0_wmode = sweep || (fire && req_write);
    assign RW0_addr  = sweep ? cnt_q : fire ? req_addr : '0;
    assign RW0_wmask = sweep ? '1 : fire ? req_mask : '0;
    assign RW0_wdata = fire ? req_wdata : '0;
    assign init_done = done_q;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fire && !req_write;
            if (state_q == ST_INIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (!CLR_ON_RESET || cnt_q == AW'(DEPTH - 1)) begin
                    state_q <= ST_RUN;
                    done_q  <= 1'b1;
                end
            end
        end

    array_resp_fifo #(.WIDTH(WIDTH)) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (inflight_q),
        .push_data_i (RW0_rdata),
        .pop_i       (pop),
        .count_o     (fifo_cnt),
        .head_o      (resp_rdata)
    );
    assign resp_valid = fifo_cnt != 2'd0;
endmodule

// File: doc/array_port_ctrl.md
Name: array_port_ctrl

Overview:
- Request-side controller for the single-port masked SRAM macro (128 x 108, four 27-bit write-mask segments, 1-cycle registered-address read).
- Drives the macro's RW0_* port and zero-clears the array after reset, because the macro has no reset.
- Accepts read and write requests on a valid/ready channel.
- Returns read data in order on a valid/ready response channel, with a 2-entry buffer so responses never drop under backpressure.

Parameters:
- DEPTH, 128, macro word count
- AW, 7, address width (log2 DEPTH)
- WIDTH, 108, data width
- MASK_SEG, 4, write-mask segments
- GRAN, 27, bits per segment (WIDTH = MASK_SEG*GRAN)
- CLR_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = skip it

Ports:
- clock  in  1  sole clock; also clocks the macro
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_mask  in  MASK_SEG  segment write enables (ignored on reads)
- req_wdata  in  WIDTH  write data
- resp_valid  out  1  read data valid
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  WIDTH  read data
- init_done  out  1  high once the sweep completes; stays high until reset
- RW0_addr  out  AW  to macro
- RW0_en  out  1  to macro
- RW0_wmode  out  1  to macro
- RW0_wmask  out  MASK_SEG  to macro
- RW0_wdata  out  WIDTH  to macro
- RW0_rdata  in  WIDTH  from macro; valid the cycle after a read is issued

Behaviour:
- Reset (asynchronous, active-high): state=INIT, sweep counter=0, FIFO empty, inflight=0.
- Output values during reset: req_ready=0, resp_valid=0, resp_rdata=0, init_done=0, RW0_en=0, RW0_wmode=0, RW0_addr=0, RW0_wmask=0, RW0_wdata=0.
- FSM, 2 states: INIT -> RUN.
- INIT (CLR_ON_RESET=1):
  - Each cycle: RW0_en=1, RW0_wmode=1, RW0_wmask=all ones, RW0_wdata=0, RW0_addr=sweep counter.
  - Counter increments each cycle. After address DEPTH-1 is written, go to RUN.
  - Sweep takes exactly DEPTH cycles. init_done is registered high in the first RUN cycle. req_ready=0 throughout INIT.
- INIT (CLR_ON_RESET=0): no macro accesses; go to RUN after one cycle.
- RUN, issue path (combinational):
  - RW0_en = req_valid && req_ready.
  - RW0_wmode = req_write; RW0_addr = req_addr; RW0_wmask = req_mask; RW0_wdata = req_wdata.
  - When not firing, all RW0_* outputs drive 0.
- Write with req_mask=0: accepted, issued, array unchanged, no response.
- Read accepted in cycle N:
  - inflight=1 in cycle N+1.
  - RW0_rdata is pushed into the 2-entry FIFO at the end of cycle N+1.
  - resp_valid is high from cycle N+2 (minimum latency 2 cycles from accept).
- Credit rule: outstanding = FIFO count + inflight - (resp_valid && resp_ready). req_ready = RUN && outstanding < 2. The rule applies to writes as well, so req_ready never depends on payload. Result: with resp_ready held high, one read per cycle sustained; FIFO never overflows.
- FIFO:
  - First-in first-out; resp_rdata = head entry.
  - Simultaneous push and pop at count=2 cannot occur under the credit rule.
  - Simultaneous push and pop at count=1 leaves count=1.
- Reset asserted mid-operation: inflight reads and buffered responses are discarded; the sweep restarts at address 0.
- Read-after-write to the same address on consecutive cycles returns the new data (macro write completes before the read address is sampled).

Decomposition:
- Package array_pkg: ARRAY_DEPTH, ARRAY_AW, ARRAY_WIDTH, ARRAY_MASK_SEG, ARRAY_GRAN, and the state enum {ST_INIT, ST_RUN}.
- One sub-module, array_resp_fifo: 2-entry WIDTH-bit FIFO with push, pop, count, head outputs; async active-high reset.
- The top level holds the FSM, sweep counter, inflight flag and credit logic, and instantiates array_ext behind the controller in the bench.

Test Plan:
- Reset release, CLR_ON_RESET=1 -> RW0_en/wmode high for 128 cycles with RW0_addr 0..127, wmask=4'hF, wdata=0; init_done rises the cycle after; read addr 5 returns 108'h0.
- Write addr 7'h12 mask 4'hF data 108'hABC_0123_4567_89AB_CDEF_0123_4567, then read 7'h12 -> resp_valid 2 cycles after read accept, same data.
- Write addr 3 all ones mask 4'hF, then write zeros mask 4'b0101, then read 3 -> bits [107:81] and [53:27] all ones; [80:54] and [26:0] zero.
- resp_ready=0, 4 back-to-back reads offered -> exactly 2 accepted, then req_ready=0; raise resp_ready -> 2 responses in order, then remaining 2 accepted.
- resp_ready=1, 16 consecutive reads -> one accept per cycle, 16 responses, in order, contiguous.
- Assert reset at sweep address 60 -> all outputs 0 immediately; after release the sweep restarts at 0 and init_done rises after 128 more cycles.
